// File: rtl/btb_pkg.sv
// Shared types, sizing and PC field helpers for the branch target buffer.
// Optional same-cycle write bypass is selected with BTB_WR_BYPASS_EN in btb_predictor.
package btb_pkg;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 32 - IDX_W - 2;

  typedef logic [1:0]       ctr_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

  // Word-aligned PC: bits [1:0] never take part in indexing or tagging.
  function automatic idx_t get_idx(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic tag_t get_tag(input logic [31:0] pc);
    return pc[31:IDX_W+2];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state: increment on taken, decrement otherwise.
module sat_counter2
  import btb_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken,
  output ctr_t ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken) begin
      if (ctr_in != CTR_ST) ctr_out = ctr_in + 2'd1;
    end else begin
      if (ctr_in != CTR_SNT) ctr_out = ctr_in - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters, zero-latency lookup and a flush sweep FSM.
// Define BTB_WR_BYPASS_EN to forward a same-cycle update into the lookup result.
module btb_predictor
  import btb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic [31:0] btb_target_pc,
  output logic        btb_pc_valid,
  output logic        btb_pc_predictTaken,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush_req,
  output logic        flush_busy
);

  logic [ENTRIES-1:0] valid_q;
  ctr_t               ctr_q [ENTRIES];
  tag_t               tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  state_t state;
  idx_t   idx_cnt;

  idx_t  upd_idx;
  tag_t  upd_tag;
  logic  upd_hit;
  logic  upd_go;
  logic  upd_train;
  logic  upd_alloc;
  ctr_t  ctr_nxt;

  idx_t        look_idx;
  tag_t        look_tag;
  logic        hit_v;
  logic [31:0] hit_tgt;
  ctr_t        hit_ctr;

  // Training decode: a flush request in the same cycle takes priority over the update.
  always_comb begin
    upd_idx   = get_idx(upd_pc);
    upd_tag   = get_tag(upd_pc);
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_go    = upd_en && (state == ST_IDLE) && !flush_req;
    upd_train = upd_go && upd_hit;
    upd_alloc = upd_go && !upd_hit && upd_taken;
  end

  sat_counter2 u_ctr (
    .ctr_in  (ctr_q[upd_idx]),
    .taken   (upd_taken),
    .ctr_out (ctr_nxt)
  );

  // Flush sweep FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_cnt <= '0;
          if (flush_req) state <= ST_SWEEP;
        end
        ST_SWEEP: begin
          idx_cnt <= idx_cnt + IDX_W'(1);
          if (idx_cnt == IDX_W'(ENTRIES - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flush_busy = (state == ST_SWEEP);

  // Valid bits and counters need reset; the sweep clears one valid bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_SNT;
    end else if (state == ST_SWEEP) begin
      valid_q[idx_cnt] <= 1'b0;
    end else if (upd_alloc) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= CTR_ALLOC;
    end else if (upd_train) begin
      ctr_q[upd_idx]   <= ctr_nxt;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_alloc) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target;
    end else if (upd_train && upd_taken) begin
      tgt_q[upd_idx] <= upd_target;
    end
  end

  // Combinational lookup against the array (optionally the in-flight write).
  always_comb begin
    look_idx = get_idx(fetch_pc);
    look_tag = get_tag(fetch_pc);
    hit_v    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    hit_tgt  = tgt_q[look_idx];
    hit_ctr  = ctr_q[look_idx];
`ifdef BTB_WR_BYPASS_EN
    if ((upd_train || upd_alloc) && (upd_idx == look_idx) && (upd_tag == look_tag)) begin
      hit_v   = 1'b1;
      hit_tgt = upd_taken ? upd_target : tgt_q[upd_idx];
      hit_ctr = upd_alloc ? CTR_ALLOC : ctr_nxt;
    end
`endif
    btb_pc_valid        = (state == ST_IDLE) && hit_v;
    btb_target_pc       = btb_pc_valid ? hit_tgt : 32'h0;
    btb_pc_predictTaken = btb_pc_valid && hit_ctr[1];
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized self-checking bench for btb_predictor against an array-based behavioural model.
// Honours BTB_WR_BYPASS_EN the same way the design does.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [31:0] btb_target_pc;
  logic        btb_pc_valid;
  logic        btb_pc_predictTaken;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush_req;
  logic        flush_busy;

  btb_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_pc            (fetch_pc),
    .btb_target_pc       (btb_target_pc),
    .btb_pc_valid        (btb_pc_valid),
    .btb_pc_predictTaken (btb_pc_predictTaken),
    .upd_en              (upd_en),
    .upd_pc              (upd_pc),
    .upd_target          (upd_target),
    .upd_taken           (upd_taken),
    .flush_req           (flush_req),
    .flush_busy          (flush_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 16 entries, plain integers.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_sweep_left;

  logic        obs_valid;
  logic        obs_taken;
  logic [31:0] obs_tgt;
  logic        obs_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned pc_tag(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic int sat(input int c, input bit taken);
    int r;
    r = taken ? c + 1 : c - 1;
    if (r > 3) r = 3;
    if (r < 0) r = 0;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_sweep_left = 0;
  endtask

  // One clock: drive, compare lookup at the falling edge, advance model at the rising edge.
  task automatic cycle(input logic [31:0] fpc, input logic ue, input logic [31:0] upc,
                       input logic [31:0] utg, input logic ut, input logic fr);
    int          fi, ui;
    bit          busy, hit, upd_hit, writes, e_v;
    logic [31:0] e_tgt;
    int          e_ctr;
    fetch_pc = fpc; upd_en = ue; upd_pc = upc; upd_target = utg; upd_taken = ut; flush_req = fr;
    @(negedge clk);
    fi      = pc_idx(fpc);
    ui      = pc_idx(upc);
    busy    = (m_sweep_left > 0);
    hit     = m_valid[fi] && (m_tag[fi] == pc_tag(fpc));
    upd_hit = m_valid[ui] && (m_tag[ui] == pc_tag(upc));
    writes  = !busy && ue && !fr && (upd_hit || ut);
    e_v     = !busy && hit;
    e_tgt   = m_tgt[fi];
    e_ctr   = m_ctr[fi];
`ifdef BTB_WR_BYPASS_EN
    if (writes && fi == ui && pc_tag(fpc) == pc_tag(upc)) begin
      e_v   = 1'b1;
      e_tgt = ut ? utg : m_tgt[ui];
      e_ctr = upd_hit ? sat(m_ctr[ui], ut) : 2;
    end
`endif
    obs_valid = btb_pc_valid;
    obs_taken = btb_pc_predictTaken;
    obs_tgt   = btb_target_pc;
    obs_busy  = flush_busy;
    check("valid", 32'(btb_pc_valid), 32'(e_v));
    check("predict_taken", 32'(btb_pc_predictTaken), 32'(e_v && e_ctr >= 2));
    check("target", btb_target_pc, e_v ? e_tgt : 32'h0);
    check("flush_busy", 32'(flush_busy), 32'(busy));
    @(posedge clk);
    if (busy) begin
      m_valid[16 - m_sweep_left] = 1'b0;
      m_sweep_left--;
    end else if (fr) begin
      m_sweep_left = 16;
    end else if (writes) begin
      if (upd_hit) begin
        m_ctr[ui] = sat(m_ctr[ui], ut);
        if (ut) m_tgt[ui] = utg;
      end else begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = pc_tag(upc);
        m_tgt[ui]   = utg;
        m_ctr[ui]   = 2;
      end
    end
    #1;
  endtask

  task automatic look(input logic [31:0] fpc);
    cycle(fpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    cycle(32'h0, 1'b1, pc, tgt, taken, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tags [4];
    tags[0] = 32'h4; tags[1] = 32'h5; tags[2] = 32'h3FF_FFFF; tags[3] = 32'h123_4567;
    return (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b1; fetch_pc = 32'h100; upd_en = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; flush_req = 1'b0;
    model_reset();
    // Reset state, observed while reset is held.
    #2;
    check("rst_valid", 32'(btb_pc_valid), 32'h0);
    check("rst_taken", 32'(btb_pc_predictTaken), 32'h0);
    check("rst_target", btb_target_pc, 32'h0);
    check("rst_busy", 32'(flush_busy), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    look(32'h100);

    // Allocate and hit.
    train(32'h100, 32'h200, 1'b1);
    look(32'h100);
    check("alloc_valid", 32'(obs_valid), 32'h1);
    check("alloc_taken", 32'(obs_taken), 32'h1);
    check("alloc_target", obs_tgt, 32'h200);

    // Counter walks down and saturates at strongly-not-taken.
    train(32'h100, 32'h0, 1'b0);
    train(32'h100, 32'h0, 1'b0);
    look(32'h100);
    check("nt_valid", 32'(obs_valid), 32'h1);
    check("nt_taken", 32'(obs_taken), 32'h0);
    check("nt_target", obs_tgt, 32'h200);
    train(32'h100, 32'h0, 1'b0);
    train(32'h100, 32'h0, 1'b0);
    train(32'h100, 32'h280, 1'b1);
    look(32'h100);
    check("sat_low_taken", 32'(obs_taken), 32'h0);
    check("sat_low_target", obs_tgt, 32'h280);

    // Miss with not-taken allocates nothing.
    train(32'h108, 32'h500, 1'b0);
    look(32'h108);
    check("nt_noalloc", 32'(obs_valid), 32'h0);

    // Alias on the same index replaces the entry.
    train(32'h140, 32'h300, 1'b1);
    look(32'h100);
    check("alias_old", 32'(obs_valid), 32'h0);
    look(32'h142);
    check("alias_new", 32'(obs_valid), 32'h1);
    check("alias_target", obs_tgt, 32'h300);

    // Fill, flush, ignored update and ignored re-flush during sweep.
    train(32'h104, 32'h11, 1'b1);
    train(32'h208, 32'h22, 1'b1);
    train(32'h30C, 32'h33, 1'b1);
    cycle(32'h104, 1'b1, 32'h110, 32'h44, 1'b1, 1'b1);
    begin
      int busy_cycles = 0;
      for (int i = 0; i < 20; i++) begin
        if (i == 3) cycle(32'h208, 1'b1, 32'h114, 32'h55, 1'b1, 1'b1);
        else look(32'h104);
        if (obs_busy) busy_cycles++;
      end
      check("sweep_len", 32'(busy_cycles), 32'd16);
    end
    foreach (m_tag[i]) begin
      look(32'h100 + 32'(i) * 4);
      check("post_flush_miss", 32'(obs_valid), 32'h0);
    end
    look(32'h140); look(32'h208); look(32'h30C); look(32'h110); look(32'h114);

    // Reset mid-sweep aborts immediately.
    train(32'h180, 32'h66, 1'b1);
    cycle(32'h180, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) look(32'h180);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_busy", 32'(flush_busy), 32'h0);
    check("rst_mid_valid", 32'(btb_pc_valid), 32'h0);
    #2 rst = 1'b0;
    cycle(32'h180, 1'b1, 32'h180, 32'h400, 1'b1, 1'b0);
`ifdef BTB_WR_BYPASS_EN
    check("bypass_valid", 32'(obs_valid), 32'h1);
`else
    check("bypass_valid", 32'(obs_valid), 32'h0);
`endif
    look(32'h180);
    check("after_upd_valid", 32'(obs_valid), 32'h1);
    check("after_upd_target", obs_tgt, 32'h400);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? rand_pc() : 32'h0;
      if ($urandom_range(0, 3) == 0) p = rand_pc();
      cycle($urandom_range(0, 2) == 0 && p != 0 ? p : rand_pc(),
            1'($urandom_range(0, 1)), p != 0 ? p : rand_pc(), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
